// File: rtl/soc_pm_data_resp_pkg.sv
// Shared types and constants for the pixel-matrix data responder.
// Used by the chain emulation, the interface and the top-level FSM.
package soc_pm_data_resp_pkg;

    localparam int DATA_W = 32;

    // Bit positions inside chain_sel
    localparam int SEL_A = 0;
    localparam int SEL_B = 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } pm_resp_state_t;

endpackage

// File: rtl/soc_pm_data_responder_if.sv
// Data bus between the SoC pixel-matrix master and the responder.
// The responder is the slave: it drives both chain outputs and reads din.
interface soc_pm_data;
    import soc_pm_data_resp_pkg::*;

    logic [DATA_W-1:0] dout_a;
    logic [DATA_W-1:0] dout_b;
    logic [DATA_W-1:0] din;

    modport slave  (output dout_a, output dout_b, input din);
    modport master (input dout_a, input dout_b, output din);

endinterface

// File: rtl/soc_pm_data_responder_chain.sv
// One emulated pixel-matrix shift chain of DEPTH 32-bit words.
// Supports shifting din in, a saturating increment of every word, and clear.
module pm_shift_chain
    import soc_pm_data_resp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic              inc,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] word_q [DEPTH];

    // Clear wins over shift, and shift wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
            end
        end else if (shift) begin
            word_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                word_q[i] <= word_q[i-1];
            end
        end else if (inc) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= (word_q[i] == '1) ? word_q[i] : word_q[i] + DATA_W'(1);
            end
        end
    end

    assign dout = word_q[DEPTH-1];

endmodule

// File: rtl/soc_pm_data_responder.sv
// Pixel-matrix data responder: two emulated shift chains plus the command FSM
// that handles single shifts, automatic full-chain scans, count and clear.
module soc_pm_data_responder
    import soc_pm_data_resp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    soc_pm_data.slave        pm_data,
    input  logic [1:0]       chain_sel,
    input  logic             shift_req,
    input  logic             scan_start,
    input  logic             count,
    input  logic             clear,
    output logic             shifting,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(DEPTH);

    pm_resp_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       scanSel_q, scanSel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             shiftEn;
    logic [1:0]       shiftSel;
    logic [1:0]       incSel;
    logic [1:0]       clrSel;
    logic [DATA_W-1:0] doutA;
    logic [DATA_W-1:0] doutB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scanSel_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scanSel_q <= scanSel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // A scan ignores the live chain_sel for shifting but a clear still uses it
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scanSel_d = scanSel_q;
        done_d    = 1'b0;
        shiftEn   = 1'b0;
        shiftSel  = 2'b00;
        incSel    = 2'b00;
        clrSel    = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    clrSel = chain_sel;
                end else if (scan_start) begin
                    scanSel_d = chain_sel;
                    cnt_d     = '0;
                    state_d   = SCAN;
                end else if (shift_req) begin
                    shiftEn  = 1'b1;
                    shiftSel = chain_sel;
                end else if (count) begin
                    incSel = chain_sel;
                end
            end
            SCAN: begin
                if (clear) begin
                    clrSel  = chain_sel;
                    state_d = IDLE;
                end else begin
                    shiftEn  = 1'b1;
                    shiftSel = scanSel_q;
                    if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SCAN);
    end

    pm_shift_chain #(.DEPTH(DEPTH)) chainA (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (shiftEn && shiftSel[SEL_A]),
        .inc   (incSel[SEL_A]),
        .clr   (clrSel[SEL_A]),
        .din   (pm_data.din),
        .dout  (doutA)
    );

    pm_shift_chain #(.DEPTH(DEPTH)) chainB (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (shiftEn && shiftSel[SEL_B]),
        .inc   (incSel[SEL_B]),
        .clr   (clrSel[SEL_B]),
        .din   (pm_data.din),
        .dout  (doutB)
    );

    assign pm_data.dout_a = doutA;
    assign pm_data.dout_b = doutB;
    assign shifting       = shiftEn;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_soc_pm_data_responder.sv
// Testbench for soc_pm_data_responder with DEPTH=4: directed scenarios then
// random commands, compared against a queue-based model of the two chains.
module tb_soc_pm_data_responder;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] chainSel;
    logic       shiftReq;
    logic       scanStart;
    logic       countCmd;
    logic       clearCmd;
    logic       shifting;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Reference model: each chain is a queue, front = word[0], back = dout
    logic [31:0] modelA[$];
    logic [31:0] modelB[$];
    bit          modelInScan;
    int          modelLeft;
    logic [1:0]  modelScanSel;
    bit          modelDone;

    soc_pm_data pmIf ();

    soc_pm_data_responder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pm_data    (pmIf.slave),
        .chain_sel  (chainSel),
        .shift_req  (shiftReq),
        .scan_start (scanStart),
        .count      (countCmd),
        .clear      (clearCmd),
        .shifting   (shifting),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        modelA.delete();
        modelB.delete();
        for (int i = 0; i < DEPTH; i++) begin
            modelA.push_back(32'd0);
            modelB.push_back(32'd0);
        end
        modelInScan  = 1'b0;
        modelLeft    = 0;
        modelScanSel = 2'b00;
        modelDone    = 1'b0;
    endtask

    task automatic modelShift(input logic [1:0] sel, input logic [31:0] d);
        if (sel[0]) begin
            modelA.push_front(d);
            void'(modelA.pop_back());
        end
        if (sel[1]) begin
            modelB.push_front(d);
            void'(modelB.pop_back());
        end
    endtask

    task automatic modelClear(input logic [1:0] sel);
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[0]) modelA[i] = 32'd0;
            if (sel[1]) modelB[i] = 32'd0;
        end
    endtask

    task automatic modelCount(input logic [1:0] sel);
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[0] && modelA[i] != 32'hFFFF_FFFF) modelA[i] = modelA[i] + 32'd1;
            if (sel[1] && modelB[i] != 32'hFFFF_FFFF) modelB[i] = modelB[i] + 32'd1;
        end
    endtask

    // Apply the command rules for one rising edge with the current inputs
    task automatic modelEdge();
        modelDone = 1'b0;
        if (!modelInScan) begin
            if (clearCmd) begin
                modelClear(chainSel);
            end else if (scanStart) begin
                modelInScan  = 1'b1;
                modelScanSel = chainSel;
                modelLeft    = DEPTH;
            end else if (shiftReq) begin
                modelShift(chainSel, pmIf.din);
            end else if (countCmd) begin
                modelCount(chainSel);
            end
        end else begin
            if (clearCmd) begin
                modelClear(chainSel);
                modelInScan = 1'b0;
            end else begin
                modelShift(modelScanSel, pmIf.din);
                modelLeft--;
                if (modelLeft == 0) begin
                    modelInScan = 1'b0;
                    modelDone   = 1'b1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".dout_a"}, pmIf.dout_a, modelA[DEPTH-1]);
        check({tag, ".dout_b"}, pmIf.dout_b, modelB[DEPTH-1]);
        check({tag, ".busy"},   {31'd0, busy}, {31'd0, modelInScan});
        check({tag, ".done"},   {31'd0, done}, {31'd0, modelDone});
    endtask

    // One clock cycle: drive, check shifting before the edge, then registered outputs after
    task automatic applyStimulus(input string tag, input logic [1:0] sel, input logic shr,
                                 input logic scs, input logic cnt, input logic clr,
                                 input logic [31:0] d);
        bit expShift;
        chainSel  = sel;
        shiftReq  = shr;
        scanStart = scs;
        countCmd  = cnt;
        clearCmd  = clr;
        pmIf.din  = d;
        #1;
        expShift = modelInScan ? !clr : (shr && !clr && !scs);
        check({tag, ".shifting"}, {31'd0, shifting}, {31'd0, expShift});
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(tag, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        chainSel  = 2'b00;
        shiftReq  = 1'b0;
        scanStart = 1'b0;
        countCmd  = 1'b0;
        clearCmd  = 1'b0;
        pmIf.din  = 32'd0;
        modelReset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        check("reset.shifting", {31'd0, shifting}, 32'd0);
        rst_n = 1'b1;
        idleCycle("postReset");

        // Single shifts into A only
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus("shiftA", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'(i));
        end
        check("shiftA.final_a", pmIf.dout_a, 32'd1);
        check("shiftA.final_b", pmIf.dout_b, 32'd0);

        // Preload both chains with 1..4, then scan 10..13 through them
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus("preloadAB", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'(i));
        end
        applyStimulus("scanStart", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'd99);
        check("scanStart.busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("scanShift", 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'(10 + i));
        end
        check("scanEnd.dout_a", pmIf.dout_a, 32'd10);
        check("scanEnd.dout_b", pmIf.dout_b, 32'd10);
        check("scanEnd.done", {31'd0, done}, 32'd1);
        check("scanEnd.busy", {31'd0, busy}, 32'd0);
        idleCycle("afterScan");
        check("afterScan.done", {31'd0, done}, 32'd0);

        // Saturating count on B; A must stay as it was
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("preloadB", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("countB", 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            check("satB.word", pmIf.dout_b, 32'hFFFF_FFFF);
            applyStimulus("drainB", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7);
        end
        check("satB.a_held", pmIf.dout_a, 32'd10);

        // Clear beats shift and count in IDLE
        applyStimulus("priority", 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55);
        for (int i = 0; i < DEPTH; i++) begin
            check("priority.a_zero", pmIf.dout_a, 32'd0);
            applyStimulus("drainA", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        end

        // Clear during the second scan cycle aborts after one shift
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus("preloadAbort", 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'(20 + i));
        end
        applyStimulus("abortStart", 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus("abortShift", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'd30);
        check("abortShift.dout_a", pmIf.dout_a, 32'd22);
        applyStimulus("abortClear", 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 32'd31);
        check("abortClear.busy", {31'd0, busy}, 32'd0);
        check("abortClear.done", {31'd0, done}, 32'd0);
        check("abortClear.dout_b", pmIf.dout_b, 32'd22);
        idleCycle("afterAbort");

        // Asynchronous reset in the middle of a scan
        applyStimulus("rstScanStart", 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus("rstScanShift", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'hABCD);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midScanReset");
        check("midScanReset.shifting", {31'd0, shifting}, 32'd0);
        #2;
        rst_n = 1'b1;
        idleCycle("afterMidReset");

        // Random command mix
        for (int n = 0; n < 400; n++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom();
            applyStimulus("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 19) == 0), d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_pm_data_responder.md
# soc_pm_data_responder

Synthesizable responder for the `soc_pm_data` interface: it drives `dout_a` and `dout_b` and consumes `din` on the slave modport. It emulates two 32-bit-wide pixel-matrix shift chains, A and B, so the SoC pixel-matrix master can be exercised on FPGA and in simulation without the analog matrix. It supports single shifts, an automatic full-chain scan, hit-counter injection and clear.

## Interface
Parameters:
- `DEPTH`, default 8: words per chain; must be ≥ 2.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `pm_data`  modport `soc_pm_data.slave`: drives `dout_a` and `dout_b` (32 bits each); reads `din` (32 bits).
- `chain_sel`  in  2: bit0 selects chain A, bit1 selects chain B. Sampled on every accepted command and held for the whole scan.
- `shift_req`  in  1: single-shift request, one cycle per shift.
- `scan_start`  in  1: start an automatic scan of `DEPTH` shifts.
- `count`  in  1: increment every word of the selected chains, saturating.
- `clear`  in  1: zero the selected chains and abort any scan.
- `shifting`  out  1: combinational; high in every cycle whose closing edge performs a shift. The master must hold `din` valid across that edge.
- `busy`  out  1: registered; high while the state is SCAN.
- `done`  out  1: registered; one-cycle pulse after the last scan shift.

## Operation
- Storage per chain: `word[0..DEPTH-1]`, each 32 bits.
- `dout_a` = A.`word[DEPTH-1]`; `dout_b` = B.`word[DEPTH-1]`. Both are register outputs with no combinational path from `din`.
- Shift on a selected chain: `word[0]` ← `din`, and `word[i]` ← `word[i-1]`. Unselected chains hold their values.
- Count: each word ← `word + 1`, saturating at 32'hFFFF_FFFF with no wrap.
- Clear: the selected chains ← 0.
- `chain_sel` = 2'b00 makes any command a no-op on storage. FSM effects still apply: a scan runs and pulses `done`.

FSM states, defined in the package enum:
- IDLE:
  - Priority `clear` > `scan_start` > `shift_req` > `count`. The highest-priority command is executed and the rest are dropped.
  - On `scan_start`: latch `chain_sel`, set `cnt` ← 0, go to SCAN. No shift happens on the accepting edge.
- SCAN:
  - Every edge shifts the latched chains and increments `cnt`.
  - When the edge with `cnt` == `DEPTH-1` shifts, go to IDLE and set `done` for one cycle.
  - `clear` in SCAN clears the chains selected by the live `chain_sel`, goes to IDLE, and does not pulse `done`.
  - `shift_req`, `count` and `scan_start` are ignored in SCAN.
- `cnt` width is `$clog2(DEPTH)`. It only runs 0 to `DEPTH-1`, so it never wraps.
- `shifting` = (state == SCAN && !`clear`) || (state == IDLE && `shift_req` && !`clear` && !`scan_start`).

## Timing
- Reset values: all words 0, state IDLE, `cnt` 0, `busy` 0, `done` 0. As a result `dout_a` = `dout_b` = 0 and `shifting` = 0.
- Single-shift latency: `din` sampled at edge n appears on `dout` after `DEPTH` shifts. `dout` changes at the edge of each shift.
- Scan timing:
  - `scan_start` accepted at edge n.
  - `busy` is high from n until edge n+`DEPTH`; shifts occur at edges n+1 through n+`DEPTH`.
  - `done` is high for the cycle after edge n+`DEPTH`.
  - A new `scan_start` presented in that same cycle is accepted.
- Count and clear take effect at the edge where they are sampled.
- Reset asserted mid-scan: immediate return to reset values with no `done` pulse.

## Structure
- Package `soc_pm_data_resp_pkg`:
  - `pm_resp_state_t` enum {IDLE, SCAN}.
  - Constants `SEL_A` = 0 and `SEL_B` = 1 (bit indices into `chain_sel`).
- Sub-module `pm_shift_chain`, instantiated twice:
  - Parameter `DEPTH`.
  - Inputs `clk`, `rst_n`, `shift`, `inc`, `clr`, `din[31:0]`; output `dout[31:0]`.
  - Precedence inside: `clr` > `shift` > `inc`.
- The top holds the FSM, the command priority decode and the per-chain enables.

## Test plan
All scenarios use `DEPTH`=4.
- Reset check: `rst_n` low then high → `dout_a` = `dout_b` = 0, `busy` = 0, `done` = 0, `shifting` = 0.
- Single shifts on A: `chain_sel`=01; four `shift_req` with `din` = 1, 2, 3, 4 → `dout_a` = 1 after the 4th shift; `dout_b` stays 0 throughout.
- Scan on both chains: chains preloaded with 1..4; `chain_sel`=11; `scan_start` with `din` = 10, 11, 12, 13 on the shift edges → `dout_a` and `dout_b` each show 2, 3, 4, then 10 in turn; `busy` high for 4 cycles; `done` high for 1 cycle.
- Saturating count: B preloaded with FFFF_FFFE everywhere; `chain_sel`=10; `count` for 3 cycles → all B words = FFFF_FFFF, and A is unchanged.
- Priority in IDLE: `clear`, `shift_req` and `count` asserted together with `chain_sel`=01 → A becomes all 0, `shifting` = 0 in that cycle, and no increment occurs.
- Abort paths:
  - `clear` in the 2nd SCAN cycle → IDLE next cycle, no `done` pulse, only 1 shift performed.
  - `rst_n` pulsed low mid-scan → all outputs return to 0 immediately.
